// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Loads hit in zero cycles; misses and all stores stall until backing memory acks.
module data_cache #(
    parameter int WIDTH = 32,
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR} state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [WIDTH-1:0]   data_q [SETS];
    logic [WIDTH-3:0]   addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]   cpu_idx, lat_idx;
    logic [TAG_W-1:0]   cpu_tag, lat_tag;
    logic               is_store, is_load, cpu_hit, lat_hit;
    logic               unused_addr_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign cpu_idx  = cpu_addr[IDX_W+1:2];
    assign cpu_tag  = cpu_addr[WIDTH-1:IDX_W+2];
    assign lat_idx  = addr_q[IDX_W-1:0];
    assign lat_tag  = addr_q[WIDTH-3:IDX_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    // A simultaneous load and store is treated as a store.
    assign is_store = cpu_we;
    assign is_load  = cpu_re & ~cpu_we;
    assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_hit  = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag/data arrays and request latches carry no reset; a reset cycle only suppresses writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == MEM_RD && mem_ack) begin
                tag_q[lat_idx]  <= lat_tag;
                data_q[lat_idx] <= mem_rdata;
            end else if (state_q == MEM_WR && mem_ack && lat_hit) begin
                data_q[lat_idx] <= wdata_q;
            end
            if (state_q == IDLE && (cpu_re || cpu_we)) begin
                addr_q  <= cpu_addr[WIDTH-1:2];
                wdata_q <= cpu_wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (is_store) begin
                    state_d = MEM_WR;
                end else if (is_load && cpu_hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else if (is_load) begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    state_d    = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    valid_d[lat_idx] = 1'b1;
                    state_d          = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_store) begin
                    stall = 1'b1;
                end else if (is_load && cpu_hit) begin
                    cpu_rdata = data_q[cpu_idx];
                end else if (is_load) begin
                    stall = 1'b1;
                end
            end
            MEM_RD: begin
                mem_req = 1'b1;
                stall   = ~mem_ack;
                if (mem_ack) cpu_rdata = mem_rdata;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall   = ~mem_ack;
            end
            default: ;
        endcase
    end

    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
